// File: rtl/model_tick_pkg.sv
// rtl/model_tick_pkg.sv - shared mode encodings, FSM states and widths for the model tick generator
package model_tick_pkg;

   localparam int DIV_SEL_W = 5;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_FREE  = 2'd1;
   localparam logic [1:0] MODE_STEP  = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BURST = 2'd2
   } tick_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser for an asynchronous input plus rising-edge pulse
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              edge_q;
   logic              edge_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_i};
      edge_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         edge_q <= edge_d;
      end
   end

   // Combinational pulse from flop outputs only; the consumer registers it.
   assign rise_o = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/model_tick_gen.sv
// rtl/model_tick_gen.sv - model-clock tick source: off, free-run divider, single-step and counted burst
module model_tick_gen
   import model_tick_pkg::*;
#(
   parameter int DIV_WIDTH   = 24,
   parameter int BURST_WIDTH = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode,
   input  logic [DIV_SEL_W-1:0]   div_sel,
   input  logic                   step_btn,
   input  logic                   burst_start,
   input  logic [BURST_WIDTH-1:0] burst_len,
   output logic                   tick_o,
   output logic                   model_clk_o,
   output logic                   busy_o,
   output logic [CNT_WIDTH-1:0]   tick_count_o
);

   localparam logic [DIV_WIDTH:0] ONE_W = {{DIV_WIDTH{1'b0}}, 1'b1};

   tick_state_e             state_q, state_d;
   logic [DIV_WIDTH-1:0]    presc_q, presc_d;
   logic [BURST_WIDTH-1:0]  remaining_q, remaining_d;
   logic [1:0]              mode_q, mode_d;
   logic [DIV_SEL_W-1:0]    div_sel_q, div_sel_d;
   logic                    tick_q, tick_d;
   logic                    model_clk_q, model_clk_d;
   logic                    busy_q, busy_d;
   logic [CNT_WIDTH-1:0]    tick_count_q, tick_count_d;

   logic                    step_rise;
   logic                    cfg_change;
   logic [DIV_WIDTH:0]      term_val;
   logic                    presc_terminal;

   sync_edge_detect #(
      .STAGES (SYNC_STAGES)
   ) u_step_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (step_btn),
      .rise_o  (step_rise)
   );

   // Terminal prescaler value is 2**eff-1 with eff clamped to the counter width.
   always_comb begin
      if (int'(div_sel_q) >= DIV_WIDTH) begin
         term_val = {1'b0, {DIV_WIDTH{1'b1}}};
      end else begin
         term_val = (ONE_W << div_sel_q) - ONE_W;
      end
      presc_terminal = ({1'b0, presc_q} == term_val);
   end

   always_comb begin
      cfg_change = (mode != mode_q) || (div_sel != div_sel_q);
      mode_d     = mode;
      div_sel_d  = div_sel;
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      tick_d      = 1'b0;

      if (cfg_change) begin
         // A new mode or divider restarts the timebase and abandons any burst.
         presc_d     = '0;
         remaining_d = '0;
         busy_d      = 1'b0;
         state_d     = (mode == MODE_FREE) ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mode_q == MODE_FREE) begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end else if (mode_q == MODE_STEP) begin
                  tick_d = step_rise;
               end else if ((mode_q == MODE_BURST) && burst_start &&
                            (burst_len != '0)) begin
                  remaining_d = burst_len;
                  presc_d     = '0;
                  busy_d      = 1'b1;
                  state_d     = ST_BURST;
               end
            end

            ST_RUN: begin
               if (mode_q != MODE_FREE) begin
                  state_d = ST_IDLE;
                  presc_d = '0;
               end else if (presc_terminal) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
               end else begin
                  presc_d = presc_q + DIV_WIDTH'(1);
               end
            end

            ST_BURST: begin
               // The last tick leaves remaining at zero; busy drops one cycle later.
               if (remaining_q == '0) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  presc_d = '0;
               end else if (presc_terminal) begin
                  presc_d     = '0;
                  tick_d      = 1'b1;
                  remaining_d = remaining_q - BURST_WIDTH'(1);
               end else begin
                  presc_d = presc_q + DIV_WIDTH'(1);
               end
            end

            default: begin
               state_d = ST_IDLE;
               presc_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      model_clk_d  = model_clk_q ^ tick_d;
      tick_count_d = tick_count_q + CNT_WIDTH'(tick_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         remaining_q  <= '0;
         mode_q       <= MODE_OFF;
         div_sel_q    <= '0;
         tick_q       <= 1'b0;
         model_clk_q  <= 1'b0;
         busy_q       <= 1'b0;
         tick_count_q <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         remaining_q  <= remaining_d;
         mode_q       <= mode_d;
         div_sel_q    <= div_sel_d;
         tick_q       <= tick_d;
         model_clk_q  <= model_clk_d;
         busy_q       <= busy_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign tick_o       = tick_q;
   assign model_clk_o  = model_clk_q;
   assign busy_o       = busy_q;
   assign tick_count_o = tick_count_q;

endmodule

// File: tb/tb_model_tick_gen.sv
// tb/tb_model_tick_gen.sv - randomized and directed bench for model_tick_gen against a formula-based model
module tb_model_tick_gen;

   localparam int DIV_WIDTH   = 6;
   localparam int BURST_WIDTH = 8;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_WIDTH   = 4;
   localparam int HIST_MAX    = 16383;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [1:0]             mode = 2'd0;
   logic [4:0]             div_sel = 5'd0;
   logic                   step_btn = 1'b0;
   logic                   burst_start = 1'b0;
   logic [BURST_WIDTH-1:0] burst_len = '0;
   logic                   tick_o;
   logic                   model_clk_o;
   logic                   busy_o;
   logic [CNT_WIDTH-1:0]   tick_count_o;

   always #5 clk = ~clk;

   model_tick_gen #(
      .DIV_WIDTH   (DIV_WIDTH),
      .BURST_WIDTH (BURST_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode         (mode),
      .div_sel      (div_sel),
      .step_btn     (step_btn),
      .burst_start  (burst_start),
      .burst_len    (burst_len),
      .tick_o       (tick_o),
      .model_clk_o  (model_clk_o),
      .busy_o       (busy_o),
      .tick_count_o (tick_count_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: ticks are derived from edge indices relative to the
   // edge where the config or burst took effect, not from a prescaler.
   int         e_cnt;
   logic [1:0] m_q;
   logic [4:0] d_q;
   int         run_start;
   bit         b_act;
   int         b_start;
   int         b_len;
   int         mp;
   int         mk;
   bit         hist [0:HIST_MAX];
   bit         exp_tick;
   bit         exp_mclk;
   bit         exp_busy;
   int         exp_cnt;

   function automatic int period(input logic [4:0] d);
      int eff;
      eff = (int'(d) > DIV_WIDTH) ? DIV_WIDTH : int'(d);
      return 1 << eff;
   endfunction

   function automatic bit hist_at(input int i);
      if (i >= 1 && i <= HIST_MAX) return hist[i];
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt     = 0;
         m_q       = 2'd0;
         d_q       = 5'd0;
         run_start = 0;
         b_act     = 1'b0;
         b_start   = 0;
         b_len     = 0;
         exp_tick  = 1'b0;
         exp_mclk  = 1'b0;
         exp_busy  = 1'b0;
         exp_cnt   = 0;
      end else begin
         e_cnt++;
         if (e_cnt <= HIST_MAX) hist[e_cnt] = step_btn;
         exp_tick = 1'b0;
         if (mode != m_q || div_sel != d_q) begin
            m_q   = mode;
            d_q   = div_sel;
            b_act = 1'b0;
            if (mode == 2'd1) run_start = e_cnt;
         end else begin
            mp = period(d_q);
            case (m_q)
               2'd1: exp_tick = ((e_cnt - run_start) % mp) == 0;
               2'd2: exp_tick = hist_at(e_cnt - SYNC_STAGES) && !hist_at(e_cnt - SYNC_STAGES - 1);
               2'd3: begin
                  if (b_act) begin
                     mk = e_cnt - b_start;
                     if (mk == b_len * mp + 1) b_act = 1'b0;
                     else if (mk % mp == 0) exp_tick = 1'b1;
                  end else if (burst_start && burst_len != 0) begin
                     b_act   = 1'b1;
                     b_start = e_cnt;
                     b_len   = int'(burst_len);
                  end
               end
               default: ;
            endcase
         end
         exp_busy = b_act;
         if (exp_tick) begin
            exp_mclk = !exp_mclk;
            exp_cnt  = (exp_cnt + 1) % (1 << CNT_WIDTH);
         end
      end
   end

   int tick_seen = 0;

   always @(negedge clk) begin
      check_val("tick_o", 32'(tick_o), 32'(exp_tick));
      check_val("model_clk_o", 32'(model_clk_o), 32'(exp_mclk));
      check_val("busy_o", 32'(busy_o), 32'(exp_busy));
      check_val("tick_count_o", 32'(tick_count_o), 32'(exp_cnt));
      if (tick_o) tick_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_tick"}, 32'(tick_o), 32'd0);
      check_val({tag, "_mclk"}, 32'(model_clk_o), 32'd0);
      check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
      check_val({tag, "_cnt"}, 32'(tick_count_o), 32'd0);
   endtask

   int s;
   int cfg_left;

   initial begin
      cyc(3);
      #1;
      check_zero_outputs("reset");
      cyc(1);
      rst_n = 1'b1;

      // Counter wrap: 17 ticks at div 0 leave a 4-bit count at 1
      mode    = 2'd1;
      div_sel = 5'd0;
      cyc(18);
      #1;
      check_val("wrap_cnt", 32'(tick_count_o), 32'd1);
      check_val("wrap_mclk", 32'(model_clk_o), 32'd1);
      mode = 2'd0;
      cyc(10);
      #1;
      check_val("off_cnt_frozen", 32'(tick_count_o), 32'd1);
      check_val("off_mclk_frozen", 32'(model_clk_o), 32'd1);

      // Free-run div 3, then 4 changed to 2 with prescaler at 9
      mode    = 2'd1;
      div_sel = 5'd3;
      cyc(40);
      div_sel = 5'd4;
      cyc(10);
      div_sel = 5'd2;
      cyc(20);
      div_sel = 5'd7;
      cyc(140);

      // Single-step: long press, release, second press
      mode = 2'd2;
      cyc(5);
      #1;
      s = tick_seen;
      step_btn = 1'b1;
      cyc(50);
      step_btn = 1'b0;
      cyc(20);
      step_btn = 1'b1;
      cyc(20);
      step_btn = 1'b0;
      cyc(10);
      #1;
      check_val("step_ticks", 32'(tick_seen - s), 32'd2);

      // Burst of 5 at div 1 with an ignored restart
      mode    = 2'd3;
      div_sel = 5'd1;
      cyc(4);
      #1;
      s = tick_seen;
      burst_len   = 8'd5;
      burst_start = 1'b1;
      cyc(1);
      burst_start = 1'b0;
      #1;
      check_val("burst_busy_rise", 32'(busy_o), 32'd1);
      cyc(3);
      burst_start = 1'b1;
      burst_len   = 8'd3;
      cyc(1);
      burst_start = 1'b0;
      cyc(12);
      #1;
      check_val("burst_ticks", 32'(tick_seen - s), 32'd5);
      check_val("burst_busy_fall", 32'(busy_o), 32'd0);
      s = tick_seen;
      burst_len   = 8'd0;
      burst_start = 1'b1;
      cyc(1);
      burst_start = 1'b0;
      cyc(10);
      #1;
      check_val("burst_len0_ticks", 32'(tick_seen - s), 32'd0);

      // Reset in the middle of a burst of 10
      burst_len   = 8'd10;
      burst_start = 1'b1;
      cyc(1);
      burst_start = 1'b0;
      cyc(6);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      cyc(2);
      rst_n = 1'b1;
      #1;
      s = tick_seen;
      cyc(20);
      #1;
      check_val("post_reset_quiet", 32'(tick_seen - s), 32'd0);
      s = tick_seen;
      burst_len   = 8'd2;
      burst_start = 1'b1;
      cyc(1);
      burst_start = 1'b0;
      cyc(8);
      #1;
      check_val("post_reset_burst", 32'(tick_seen - s), 32'd2);

      // Randomized traffic across all modes
      cfg_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (cfg_left == 0) begin
            mode     = 2'($urandom_range(0, 3));
            div_sel  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(7, 31))
                                                   : 5'($urandom_range(0, 4));
            cfg_left = int'($urandom_range(20, 150));
         end else begin
            cfg_left--;
         end
         burst_start = ($urandom_range(0, 7) == 0);
         burst_len   = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
         cyc(1);
      end
      burst_start = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
